// File: rtl/retire_ctl.sv
// retire_ctl: in-order retirement controller for the ROB head window.
// Retires the contiguous run of completed head slots, issues registered
// register-file writes (last writer wins, r0 never written) and tracks
// IDLE/RUN/HALTED with single-step support.
// Optional statistics counters are built only when RETIRE_STATS_EN is defined.
module retire_ctl #(
  parameter int EXT_COUNT    = 4,
  parameter int EXTCOUNTLOG2 = $clog2(EXT_COUNT)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            halt,
  input  logic                            resume,
  input  logic                            step,
  input  logic [EXT_COUNT-1:0]            slot_valid,
  input  logic [EXT_COUNT-1:0]            slot_kill,
  input  logic [EXT_COUNT-1:0][4:0]       slot_dest_reg,
  input  logic [EXT_COUNT-1:0]            slot_dest_valid,
  input  logic [EXT_COUNT-1:0][31:0]      slot_result,
  output logic                            consume,
  output logic [EXTCOUNTLOG2-1:0]         consume_count,
  output logic [EXT_COUNT-1:0]            rf_wr_en,
  output logic [EXT_COUNT-1:0][4:0]       rf_wr_addr,
  output logic [EXT_COUNT-1:0][31:0]      rf_wr_data,
  output logic [1:0]                      state,
  output logic [31:0]                     retired_count,
  output logic [31:0]                     killed_count
);

  localparam int CW = $clog2(EXT_COUNT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e                       state_q, state_d;
  logic [CW-1:0]                runLen;
  logic [CW-1:0]                retireNum;
  logic [EXT_COUNT-1:0]         retireMask;
  logic [EXT_COUNT-1:0]         wrCand;
  logic [EXT_COUNT-1:0]         rf_wr_en_d;
  logic [EXT_COUNT-1:0]         rf_wr_en_q;
  logic [EXT_COUNT-1:0][4:0]    rf_wr_addr_q;
  logic [EXT_COUNT-1:0][31:0]   rf_wr_data_q;

  // Length of the unbroken run of completed slots starting at the head.
  always_comb begin
    logic stillValid;
    runLen     = '0;
    stillValid = 1'b1;
    for (int i = 0; i < EXT_COUNT; i++) begin
      if (stillValid && slot_valid[i]) begin
        runLen = runLen + CW'(1);
      end else begin
        stillValid = 1'b0;
      end
    end
  end

  // How many slots actually retire this cycle, given the control state.
  always_comb begin
    retireNum = '0;
    if (!reset) begin
      case (state_q)
        RUN:     retireNum = runLen;
        HALTED:  retireNum = (step && (runLen != '0)) ? CW'(1) : '0;
        default: retireNum = '0;
      endcase
    end
    consume       = (retireNum != '0);
    consume_count = consume ? EXTCOUNTLOG2'(retireNum - CW'(1)) : '0;
    for (int i = 0; i < EXT_COUNT; i++) begin
      retireMask[i] = (int'(retireNum) > i);
    end
  end

  // Write enables: live retired slots with a nonzero destination, and only
  // the youngest writer of any register within the retiring group.
  always_comb begin
    for (int i = 0; i < EXT_COUNT; i++) begin
      wrCand[i] = retireMask[i] && !slot_kill[i] && slot_dest_valid[i] &&
                  (slot_dest_reg[i] != 5'd0);
    end
    rf_wr_en_d = wrCand;
    for (int i = 0; i < EXT_COUNT; i++) begin
      for (int j = i + 1; j < EXT_COUNT; j++) begin
        if (wrCand[j] && (slot_dest_reg[j] == slot_dest_reg[i])) begin
          rf_wr_en_d[i] = 1'b0;
        end
      end
    end
  end

  // Control state transitions; halt outranks resume, step never moves state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (halt) state_d = HALTED;
      HALTED:  if (resume && !halt) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Register-file write port; address/data only move when that lane writes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rf_wr_en_q   <= '0;
      rf_wr_addr_q <= '0;
      rf_wr_data_q <= '0;
    end else begin
      rf_wr_en_q <= rf_wr_en_d;
      for (int i = 0; i < EXT_COUNT; i++) begin
        if (rf_wr_en_d[i]) begin
          rf_wr_addr_q[i] <= slot_dest_reg[i];
          rf_wr_data_q[i] <= slot_result[i];
        end
      end
    end
  end

`ifdef RETIRE_STATS_EN
  logic [CW-1:0] liveNum;
  logic [CW-1:0] killNum;
  logic [31:0]   retired_count_q;
  logic [31:0]   killed_count_q;

  // Split the retiring group into live and squashed instructions.
  always_comb begin
    liveNum = '0;
    killNum = '0;
    for (int i = 0; i < EXT_COUNT; i++) begin
      if (retireMask[i] && !slot_kill[i]) liveNum = liveNum + CW'(1);
      if (retireMask[i] &&  slot_kill[i]) killNum = killNum + CW'(1);
    end
  end

  // Free-running statistics, wrapping naturally at 32 bits.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retired_count_q <= '0;
      killed_count_q  <= '0;
    end else begin
      retired_count_q <= retired_count_q + 32'(liveNum);
      killed_count_q  <= killed_count_q + 32'(killNum);
    end
  end

  assign retired_count = retired_count_q;
  assign killed_count  = killed_count_q;
`else
  assign retired_count = '0;
  assign killed_count  = '0;
`endif

  assign state      = state_q;
  assign rf_wr_en   = rf_wr_en_q;
  assign rf_wr_addr = rf_wr_addr_q;
  assign rf_wr_data = rf_wr_data_q;

endmodule

// File: tb/tb_retire_ctl.sv
// tb_retire_ctl: directed scoreboard bench for retire_ctl.
// Stimulus pushes hand-computed expectations; a monitor pops and compares.
module tb_retire_ctl;

  localparam int N = 4;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 enable, halt, resume, step;
  logic [N-1:0]         slot_valid, slot_kill, slot_dest_valid;
  logic [N-1:0][4:0]    slot_dest_reg;
  logic [N-1:0][31:0]   slot_result;
  logic                 consume;
  logic [1:0]           consume_count;
  logic [N-1:0]         rf_wr_en;
  logic [N-1:0][4:0]    rf_wr_addr;
  logic [N-1:0][31:0]   rf_wr_data;
  logic [1:0]           state;
  logic [31:0]          retired_count, killed_count;

  int checks = 0;
  int fails  = 0;
  int expRetTotal = 0;
  int expKillTotal = 0;

  typedef struct {
    string             tag;
    logic              expConsume;
    logic [1:0]        expCount;
    logic [1:0]        expState;
    logic [N-1:0]      expWrEn;
    logic [N-1:0][4:0] regs;
    logic [N-1:0][31:0] res;
    logic [31:0]       expRet;
    logic [31:0]       expKill;
  } exp_t;

  exp_t expQ[$];

  retire_ctl #(.EXT_COUNT(N)) dut (
    .clock(clock), .reset(reset), .enable(enable), .halt(halt),
    .resume(resume), .step(step), .slot_valid(slot_valid),
    .slot_kill(slot_kill), .slot_dest_reg(slot_dest_reg),
    .slot_dest_valid(slot_dest_valid), .slot_result(slot_result),
    .consume(consume), .consume_count(consume_count),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .state(state), .retired_count(retired_count), .killed_count(killed_count)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic en, input logic h,
                               input logic r, input logic s,
                               input logic [N-1:0] v, input logic [N-1:0] k,
                               input logic [N-1:0] dv, input logic [19:0] regs,
                               input logic [31:0] resBase,
                               input logic expC, input logic [1:0] expCnt,
                               input logic [1:0] expSt, input logic [N-1:0] expW,
                               input int dRet, input int dKill);
    exp_t e;
    @(negedge clock);
    enable = en; halt = h; resume = r; step = s;
    slot_valid = v; slot_kill = k; slot_dest_valid = dv;
    slot_dest_reg = regs;
    for (int i = 0; i < N; i++) slot_result[i] = resBase + 32'(i);
    expRetTotal  += dRet;
    expKillTotal += dKill;
    e.tag = tag; e.expConsume = expC; e.expCount = expCnt; e.expState = expSt;
    e.expWrEn = expW; e.regs = slot_dest_reg; e.res = slot_result;
`ifdef RETIRE_STATS_EN
    e.expRet = 32'(expRetTotal); e.expKill = 32'(expKillTotal);
`else
    e.expRet = 32'd0; e.expKill = 32'd0;
`endif
    expQ.push_back(e);
  endtask

  // Monitor: combinational outputs mid-cycle, registered outputs after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput({e.tag, ".consume"}, 32'(consume), 32'(e.expConsume));
        checkOutput({e.tag, ".consume_count"}, 32'(consume_count), 32'(e.expCount));
        checkOutput({e.tag, ".state"}, 32'(state), 32'(e.expState));
        @(posedge clock);
        #1;
        checkOutput({e.tag, ".rf_wr_en"}, 32'(rf_wr_en), 32'(e.expWrEn));
        for (int i = 0; i < N; i++) begin
          if (e.expWrEn[i]) begin
            checkOutput($sformatf("%s.rf_wr_addr[%0d]", e.tag, i), 32'(rf_wr_addr[i]), 32'(e.regs[i]));
            checkOutput($sformatf("%s.rf_wr_data[%0d]", e.tag, i), rf_wr_data[i], e.res[i]);
          end
        end
        checkOutput({e.tag, ".retired_count"}, retired_count, e.expRet);
        checkOutput({e.tag, ".killed_count"}, killed_count, e.expKill);
      end
    end
  end

  // Watchdog so the run always ends with a summary.
  initial begin
    #100000;
    checks++;
    fails++;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    reset = 1'b1;
    enable = 1'b0; halt = 1'b0; resume = 1'b0; step = 1'b0;
    slot_valid = '0; slot_kill = '0; slot_dest_valid = '0;
    slot_dest_reg = '0; slot_result = '0;
    #3;
    checkOutput("rst.state", 32'(state), 32'd0);
    checkOutput("rst.rf_wr_en", 32'(rf_wr_en), 32'd0);
    checkOutput("rst.rf_wr_addr0", 32'(rf_wr_addr[0]), 32'd0);
    checkOutput("rst.rf_wr_data0", rf_wr_data[0], 32'd0);
    checkOutput("rst.retired_count", retired_count, 32'd0);
    checkOutput("rst.killed_count", killed_count, 32'd0);
    enable = 1'b1; slot_valid = 4'b1111; slot_dest_valid = 4'b1111;
    @(posedge clock); #2;
    checkOutput("rst.consume_held", 32'(consume), 32'd0);
    checkOutput("rst.state_held", 32'(state), 32'd0);
    @(negedge clock);
    enable = 1'b0; slot_valid = '0;
    reset = 1'b0;

    //            tag   en h r s  valid    kill     dv       regs {3,2,1,0}                   resBase        C  cnt st  wrEn     dR dK
    applyStimulus("v0",  1'b0,1'b0,1'b0,1'b0, 4'b1111, 4'b0000, 4'b1111, {5'd4,5'd3,5'd2,5'd1},   32'h0000_1000, 1'b0,2'd0,2'd0,4'b0000, 0,0);
    applyStimulus("v1",  1'b1,1'b0,1'b0,1'b0, 4'b1011, 4'b0000, 4'b1111, {5'd4,5'd3,5'd2,5'd1},   32'h0000_1100, 1'b0,2'd0,2'd0,4'b0000, 0,0);
    applyStimulus("v2",  1'b0,1'b0,1'b0,1'b0, 4'b1011, 4'b0000, 4'b1111, {5'd4,5'd3,5'd2,5'd1},   32'h0000_1200, 1'b1,2'd1,2'd1,4'b0011, 2,0);
    applyStimulus("v3",  1'b0,1'b0,1'b0,1'b1, 4'b1111, 4'b0010, 4'b1111, {5'd4,5'd3,5'd2,5'd1},   32'h0000_1300, 1'b1,2'd3,2'd1,4'b1101, 3,1);
    applyStimulus("v4",  1'b0,1'b0,1'b0,1'b0, 4'b0111, 4'b0000, 4'b1111, {5'd7,5'd5,5'd6,5'd5},   32'h0000_BEED, 1'b1,2'd2,2'd1,4'b0110, 3,0);
    applyStimulus("v5",  1'b0,1'b0,1'b0,1'b0, 4'b1111, 4'b0000, 4'b1011, {5'd10,5'd9,5'd8,5'd0},  32'h0000_1500, 1'b1,2'd3,2'd1,4'b1010, 4,0);
    applyStimulus("v6",  1'b0,1'b0,1'b0,1'b0, 4'b1110, 4'b0000, 4'b1111, {5'd4,5'd3,5'd2,5'd1},   32'h0000_1600, 1'b0,2'd0,2'd1,4'b0000, 0,0);
    applyStimulus("v7",  1'b0,1'b1,1'b0,1'b0, 4'b1111, 4'b0000, 4'b1111, {5'd4,5'd3,5'd2,5'd1},   32'h0000_1700, 1'b1,2'd3,2'd1,4'b1111, 4,0);
    applyStimulus("v8",  1'b0,1'b0,1'b0,1'b0, 4'b1111, 4'b0000, 4'b1111, {5'd4,5'd3,5'd2,5'd1},   32'h0000_1800, 1'b0,2'd0,2'd2,4'b0000, 0,0);
    applyStimulus("v9",  1'b0,1'b0,1'b0,1'b1, 4'b1111, 4'b0000, 4'b1111, {5'd4,5'd3,5'd2,5'd1},   32'h0000_1900, 1'b1,2'd0,2'd2,4'b0001, 1,0);
    applyStimulus("v10", 1'b0,1'b0,1'b0,1'b1, 4'b0000, 4'b0000, 4'b1111, {5'd4,5'd3,5'd2,5'd1},   32'h0000_1A00, 1'b0,2'd0,2'd2,4'b0000, 0,0);
    applyStimulus("v11", 1'b0,1'b1,1'b1,1'b0, 4'b1111, 4'b0000, 4'b1111, {5'd4,5'd3,5'd2,5'd1},   32'h0000_1B00, 1'b0,2'd0,2'd2,4'b0000, 0,0);
    applyStimulus("v12", 1'b0,1'b0,1'b1,1'b0, 4'b1111, 4'b0000, 4'b1111, {5'd4,5'd3,5'd2,5'd1},   32'h0000_1C00, 1'b0,2'd0,2'd2,4'b0000, 0,0);
    applyStimulus("v13", 1'b0,1'b0,1'b0,1'b0, 4'b1111, 4'b1111, 4'b1111, {5'd4,5'd3,5'd2,5'd1},   32'h0000_1D00, 1'b1,2'd3,2'd1,4'b0000, 0,4);
    applyStimulus("v14", 1'b0,1'b0,1'b0,1'b0, 4'b0001, 4'b0000, 4'b1111, {5'd4,5'd3,5'd2,5'd12},  32'h0000_1E00, 1'b1,2'd0,2'd1,4'b0001, 1,0);

    // Reset lands while the v14 write is being presented.
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midrst.rf_wr_en", 32'(rf_wr_en), 32'd0);
    checkOutput("midrst.state", 32'(state), 32'd0);
    checkOutput("midrst.consume", 32'(consume), 32'd0);
    checkOutput("midrst.rf_wr_addr0", 32'(rf_wr_addr[0]), 32'd0);
    checkOutput("midrst.retired_count", retired_count, 32'd0);
    checkOutput("midrst.killed_count", killed_count, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    checkOutput("midrst.rf_wr_en_hold", 32'(rf_wr_en), 32'd0);
    checkOutput("drain.queue_empty", 32'(expQ.size()), 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
